// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared types and helpers for the 2-read/1-write register file.
//               Provides the clear-engine state enum and the byte-masked
//               merge used by both the write path and the read bypass.
// Contents    : rf_state_e  - RF_IDLE / RF_CLEAR
//               byte_merge  - replace the masked bytes of old_v with new_v
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

  // Upper bound on the data width the merge helper handles. Callers size-cast
  // their operands up to this width and the result back down to their own.
  localparam int RF_MAX_W  = 512;
  localparam int RF_MAX_NB = RF_MAX_W / 8;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  // Byte i of the result comes from new_v when mask[i] is set, else old_v.
  function automatic logic [RF_MAX_W-1:0] byte_merge(
    input logic [RF_MAX_W-1:0]  old_v,
    input logic [RF_MAX_W-1:0]  new_v,
    input logic [RF_MAX_NB-1:0] mask
  );
    logic [RF_MAX_W-1:0] r;
    r = old_v;
    for (int i = 0; i < RF_MAX_NB; i++) begin
      if (mask[i]) begin
        r[8*i +: 8] = new_v[8*i +: 8];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// Module      : rf_read_port
// Description : One registered read port of the register file. Performs the
//               address range check and the same-cycle write bypass, then
//               registers data and a one-cycle valid pulse.
// Ports       : clk, rst (sync, active low)
//               rd_en_i/rd_addr_i   - qualified read request
//               entry_i             - stored entry at rd_addr_i
//               wr_en_i/wr_addr_i/wr_data_i/wr_mask_i - qualified write
//               rd_data_o/rd_valid_o - registered result
// Revision    : 1.0 - initial release
// ============================================================================
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en_i,
  input  logic [ADDR-1:0]    rd_addr_i,
  input  logic [WIDTH-1:0]   entry_i,
  input  logic               wr_en_i,
  input  logic [ADDR-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0]   wr_data_i,
  input  logic [WIDTH/8-1:0] wr_mask_i,
  output logic [WIDTH-1:0]   rd_data_o,
  output logic               rd_valid_o
);

  localparam logic [ADDR:0] c_depth = (ADDR+1)'(DEPTH);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             w_in_range;
  logic             w_hit;
  logic [WIDTH-1:0] w_rd_val;

  always_comb begin
    w_in_range = ({1'b0, rd_addr_i} < c_depth);
    // A write to the same address this cycle is forwarded so the read sees
    // the value the entry will hold after this edge.
    w_hit      = wr_en_i && (wr_addr_i == rd_addr_i);
    w_rd_val   = '0;
    if (w_in_range) begin
      if (w_hit) begin
        w_rd_val = WIDTH'(byte_merge(RF_MAX_W'(entry_i), RF_MAX_W'(wr_data_i),
                                     RF_MAX_NB'(wr_mask_i)));
      end else begin
        w_rd_val = entry_i;
      end
    end
  end

  always_comb begin
    valid_d = rd_en_i;
    data_d  = data_q;
    if (rd_en_i) begin
      data_d = w_rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_2r1w
// Description : Register file with one byte-masked write port, two
//               registered read ports with write bypass, and a sequential
//               bulk-clear engine (one entry per cycle).
// Ports       : clk, rst (sync, active low)
//               WrEn/WrAddr/WrData/WrMask - write port
//               RdEnN/RdAddrN -> RdDataN/RdValidN (N = 0,1), latency 1
//               ClrReq - start bulk clear; Busy - clear in progress
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               WrEn,
  input  logic [ADDR-1:0]    WrAddr,
  input  logic [WIDTH-1:0]   WrData,
  input  logic [WIDTH/8-1:0] WrMask,
  input  logic               RdEn0,
  input  logic [ADDR-1:0]    RdAddr0,
  output logic [WIDTH-1:0]   RdData0,
  output logic               RdValid0,
  input  logic               RdEn1,
  input  logic [ADDR-1:0]    RdAddr1,
  output logic [WIDTH-1:0]   RdData1,
  output logic               RdValid1,
  input  logic               ClrReq,
  output logic               Busy
);

  localparam int            NBYTE   = WIDTH / 8;
  localparam logic [ADDR:0] c_depth = (ADDR+1)'(DEPTH);
  localparam logic [ADDR-1:0] c_last = ADDR'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  rf_state_e        state_q, state_d;
  logic [ADDR-1:0]  clr_cnt_q, clr_cnt_d;

  logic             w_accept;
  logic             w_wr_in_range;
  logic [WIDTH-1:0] w_wr_old;
  logic [WIDTH-1:0] w_merged;
  logic             w_mem_we;
  logic [ADDR-1:0]  w_mem_addr;
  logic [WIDTH-1:0] w_mem_wdata;
  logic [WIDTH-1:0] w_entry0, w_entry1;

  // Port traffic is only honoured in IDLE, and a clear request in the same
  // cycle wins over any write or read.
  assign w_accept      = (state_q == RF_IDLE) && !ClrReq;
  assign w_wr_in_range = ({1'b0, WrAddr} < c_depth);
  assign w_wr_old      = w_wr_in_range ? mem_q[WrAddr] : '0;
  assign w_merged      = WIDTH'(byte_merge(RF_MAX_W'(w_wr_old), RF_MAX_W'(WrData),
                                           RF_MAX_NB'(WrMask)));
  assign w_entry0      = ({1'b0, RdAddr0} < c_depth) ? mem_q[RdAddr0] : '0;
  assign w_entry1      = ({1'b0, RdAddr1} < c_depth) ? mem_q[RdAddr1] : '0;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    w_mem_we    = 1'b0;
    w_mem_addr  = WrAddr;
    w_mem_wdata = w_merged;
    case (state_q)
      RF_IDLE: begin
        if (ClrReq) begin
          state_d   = RF_CLEAR;
          clr_cnt_d = '0;
        end else if (WrEn && w_wr_in_range) begin
          w_mem_we = 1'b1;
        end
      end
      RF_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = clr_cnt_q;
        w_mem_wdata = '0;
        if (clr_cnt_q == c_last) begin
          state_d   = RF_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR'(1);
        end
      end
      default: begin
        state_d = RF_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RF_IDLE;
      clr_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      if (w_mem_we) begin
        mem_q[w_mem_addr] <= w_mem_wdata;
      end
    end
  end

  assign Busy = (state_q == RF_CLEAR);

  rf_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR  (ADDR)
  ) u_rd0 (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (RdEn0 && w_accept),
    .rd_addr_i  (RdAddr0),
    .entry_i    (w_entry0),
    .wr_en_i    (WrEn && w_accept),
    .wr_addr_i  (WrAddr),
    .wr_data_i  (WrData),
    .wr_mask_i  (WrMask[NBYTE-1:0]),
    .rd_data_o  (RdData0),
    .rd_valid_o (RdValid0)
  );

  rf_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR  (ADDR)
  ) u_rd1 (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (RdEn1 && w_accept),
    .rd_addr_i  (RdAddr1),
    .entry_i    (w_entry1),
    .wr_en_i    (WrEn && w_accept),
    .wr_addr_i  (WrAddr),
    .wr_data_i  (WrData),
    .wr_mask_i  (WrMask[NBYTE-1:0]),
    .rd_data_o  (RdData1),
    .rd_valid_o (RdValid1)
  );

endmodule
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_2r1w
// Description : Self-checking bench for reg_file_2r1w. Two instances
//               (DEPTH=8 and DEPTH=6) share one stimulus stream; a
//               behavioural model predicts every output on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        WrEn = 1'b0;
  logic [2:0]  WrAddr = '0;
  logic [15:0] WrData = '0;
  logic [1:0]  WrMask = '0;
  logic        RdEn0 = 1'b0;
  logic [2:0]  RdAddr0 = '0;
  logic        RdEn1 = 1'b0;
  logic [2:0]  RdAddr1 = '0;
  logic        ClrReq = 1'b0;

  logic [15:0] d8_rd0, d8_rd1, d6_rd0, d6_rd1;
  logic        d8_v0, d8_v1, d8_busy, d6_v0, d6_v1, d6_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file_2r1w #(.WIDTH(16), .DEPTH(8)) u_d8 (
    .clk(clk), .rst(rst), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .WrMask(WrMask), .RdEn0(RdEn0), .RdAddr0(RdAddr0), .RdData0(d8_rd0),
    .RdValid0(d8_v0), .RdEn1(RdEn1), .RdAddr1(RdAddr1), .RdData1(d8_rd1),
    .RdValid1(d8_v1), .ClrReq(ClrReq), .Busy(d8_busy)
  );

  reg_file_2r1w #(.WIDTH(16), .DEPTH(6)) u_d6 (
    .clk(clk), .rst(rst), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .WrMask(WrMask), .RdEn0(RdEn0), .RdAddr0(RdAddr0), .RdData0(d6_rd0),
    .RdValid0(d6_v0), .RdEn1(RdEn1), .RdAddr1(RdAddr1), .RdData1(d6_rd1),
    .RdValid1(d6_v1), .ClrReq(ClrReq), .Busy(d6_busy)
  );

  // ---------------- behavioural model (index 0: DEPTH 8, 1: DEPTH 6) -------
  int          m_dep [2] = '{8, 6};
  logic [15:0] m_mem [2][8];
  logic [15:0] m_rd0 [2];
  logic [15:0] m_rd1 [2];
  logic        m_v0  [2];
  logic        m_v1  [2];
  int          m_left[2];   // clear cycles still to run; >0 means busy

  task automatic model_step(input int k);
    logic [15:0] nv;
    int d;
    d = m_dep[k];
    if (!rst) begin
      for (int i = 0; i < 8; i++) m_mem[k][i] = 16'h0;
      m_rd0[k] = 16'h0; m_rd1[k] = 16'h0;
      m_v0[k] = 1'b0;   m_v1[k] = 1'b0;
      m_left[k] = 0;
    end else if (m_left[k] > 0) begin
      m_mem[k][d - m_left[k]] = 16'h0;
      m_left[k] = m_left[k] - 1;
      m_v0[k] = 1'b0; m_v1[k] = 1'b0;
    end else if (ClrReq) begin
      m_left[k] = d;
      m_v0[k] = 1'b0; m_v1[k] = 1'b0;
    end else begin
      // Apply the write first; a read then sees exactly what a read on the
      // next cycle would see.
      if (WrEn && int'(WrAddr) < d) begin
        nv = m_mem[k][WrAddr];
        for (int b = 0; b < 2; b++)
          if (WrMask[b]) nv[8*b +: 8] = WrData[8*b +: 8];
        m_mem[k][WrAddr] = nv;
      end
      m_v0[k] = RdEn0;
      m_v1[k] = RdEn1;
      if (RdEn0) m_rd0[k] = (int'(RdAddr0) < d) ? m_mem[k][RdAddr0] : 16'h0;
      if (RdEn1) m_rd1[k] = (int'(RdAddr1) < d) ? m_mem[k][RdAddr1] : 16'h0;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    chk("d8_rd0",  d8_rd0, m_rd0[0]);
    chk("d8_rd1",  d8_rd1, m_rd1[0]);
    chk("d8_v0",   16'(d8_v0), 16'(m_v0[0]));
    chk("d8_v1",   16'(d8_v1), 16'(m_v1[0]));
    chk("d8_busy", 16'(d8_busy), 16'(m_left[0] > 0));
    chk("d6_rd0",  d6_rd0, m_rd0[1]);
    chk("d6_rd1",  d6_rd1, m_rd1[1]);
    chk("d6_v0",   16'(d6_v0), 16'(m_v0[1]));
    chk("d6_v1",   16'(d6_v1), 16'(m_v1[1]));
    chk("d6_busy", 16'(d6_busy), 16'(m_left[1] > 0));
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] m);
    WrEn = 1'b1; WrAddr = a; WrData = d; WrMask = m;
    step();
    WrEn = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a0, input logic [2:0] a1);
    RdEn0 = 1'b1; RdAddr0 = a0; RdEn1 = 1'b1; RdAddr1 = a1;
    step();
    RdEn0 = 1'b0; RdEn1 = 1'b0;
  endtask

  // Pins DUT output and model prediction to a hand-computed literal.
  task automatic lit(input string nm, input logic [15:0] act,
                     input logic [15:0] mdl, input logic [15:0] exp);
    chk({nm, "_dut"}, act, exp);
    chk({nm, "_model"}, mdl, exp);
  endtask

  int busy8, busy6;

  initial begin
    // Reset state
    step(); step();
    lit("rst_busy", 16'(d8_busy), 16'(m_left[0] > 0), 16'h0);
    lit("rst_v0", 16'(d8_v0), 16'(m_v0[0]), 16'h0);
    lit("rst_rd0", d8_rd0, m_rd0[0], 16'h0);
    rst = 1'b1;

    // Reset clears storage
    wr(3'd3, 16'hBEEF, 2'b11);
    rst = 1'b0; step(); rst = 1'b1;
    rd(3'd3, 3'd3);
    lit("rst_entry", d8_rd0, m_rd0[0], 16'h0000);
    lit("rst_entry_v", 16'(d8_v0), 16'(m_v0[0]), 16'h0001);

    // Byte mask
    wr(3'd2, 16'h1234, 2'b11);
    wr(3'd2, 16'hABCD, 2'b01);
    rd(3'd2, 3'd2);
    lit("mask_rd0", d8_rd0, m_rd0[0], 16'h12CD);
    lit("mask_d6_rd1", d6_rd1, m_rd1[1], 16'h12CD);
    step();
    lit("hold_rd0", d8_rd0, m_rd0[0], 16'h12CD);
    lit("hold_v0", 16'(d8_v0), 16'(m_v0[0]), 16'h0000);

    // Dual read with bypass, full then partial mask
    wr(3'd5, 16'h1111, 2'b11);
    WrEn = 1'b1; WrAddr = 3'd5; WrData = 16'h5555; WrMask = 2'b11;
    RdEn0 = 1'b1; RdAddr0 = 3'd5; RdEn1 = 1'b1; RdAddr1 = 3'd5;
    step();
    lit("byp_rd0", d8_rd0, m_rd0[0], 16'h5555);
    lit("byp_rd1", d8_rd1, m_rd1[0], 16'h5555);
    WrData = 16'hAA00; WrMask = 2'b10; RdAddr1 = 3'd2;
    step();
    WrEn = 1'b0; RdEn0 = 1'b0; RdEn1 = 1'b0;
    lit("byp_part_rd0", d8_rd0, m_rd0[0], 16'hAA55);
    lit("byp_other_rd1", d8_rd1, m_rd1[0], 16'h12CD);

    // Bulk clear: priority over same-cycle write/read, ignore traffic while busy
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hFFFF, 2'b11);
    ClrReq = 1'b1;
    WrEn = 1'b1; WrAddr = 3'd0; WrData = 16'h1234; WrMask = 2'b11;
    RdEn0 = 1'b1; RdAddr0 = 3'd0;
    step();
    ClrReq = 1'b0;
    lit("clr_prio_v0", 16'(d8_v0), 16'(m_v0[0]), 16'h0000);
    busy8 = 0; busy6 = 0;
    for (int c = 0; c < 12; c++) begin
      if (d8_busy) busy8++;
      if (d6_busy) busy6++;
      WrEn = (c < 6); WrAddr = 3'd1;
      RdEn0 = (c < 6);
      ClrReq = (c == 2);
      step();
    end
    WrEn = 1'b0; RdEn0 = 1'b0; ClrReq = 1'b0;
    chk("busy_len_d8", 16'(busy8), 16'd8);
    chk("busy_len_d6", 16'(busy6), 16'd6);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), 3'(i));
      lit("clr_entry", d8_rd0, m_rd0[0], 16'h0000);
    end

    // Reset during clear aborts it
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hFFFF, 2'b11);
    ClrReq = 1'b1; step(); ClrReq = 1'b0;
    step(); step();
    rst = 1'b0; step(); rst = 1'b1;
    lit("abort_busy8", 16'(d8_busy), 16'(m_left[0] > 0), 16'h0000);
    lit("abort_busy6", 16'(d6_busy), 16'(m_left[1] > 0), 16'h0000);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), 3'(7 - i));
      lit("abort_entry", d8_rd1, m_rd1[0], 16'h0000);
    end

    // Out of range on the DEPTH=6 instance; in range on DEPTH=8
    wr(3'd6, 16'h7777, 2'b11);
    wr(3'd7, 16'h4242, 2'b01);
    rd(3'd6, 3'd7);
    lit("oor_d6_rd0", d6_rd0, m_rd0[1], 16'h0000);
    lit("oor_d6_v0", 16'(d6_v0), 16'(m_v0[1]), 16'h0001);
    lit("oor_d6_rd1", d6_rd1, m_rd1[1], 16'h0000);
    lit("inr_d8_rd0", d8_rd0, m_rd0[0], 16'h7777);
    lit("inr_d8_rd1", d8_rd1, m_rd1[0], 16'h0042);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
